// File: rtl/fetch_pf.sv
// rtl/fetch_pf.sv - prefetching instruction fetch unit with tagged flush
//
// Purpose: keeps up to MAX_OT core-bus reads in flight and collects the returned
// words in an L0 FIFO of L0_BUFFER_SIZE entries {instr, pc, fault}. A jump or stop
// marks in-flight entries stale instead of draining them.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   instr_cb_mosi_o     core-bus read request (write channel tied off)
//   instr_cb_miso_i     core-bus read address ready / read response
//   fetch_start_i       enable; low stops issue and flushes
//   fetch_start_addr_i  PC loaded while rst is high
//   fetch_req_i/addr_i  jump pulse and target from EXEC
//   fetch_valid_o/ready_i, fetch_instr_o, fetch_pc_o  decode handshake
//   trap_info_o         instruction access fault of the head entry

package nox_pkg;
  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_raw_t;
  typedef enum logic [2:0] {CB_BYTE = 3'd0, CB_HWORD = 3'd1, CB_WORD = 3'd2, CB_DWORD = 3'd3} cb_size_t;
  typedef enum logic [1:0] {CB_OKAY = 2'd0, CB_EXOKAY = 2'd1, CB_SLVERR = 2'd2, CB_DECERR = 2'd3} cb_error_t;
  typedef struct packed {
    pc_t         wr_addr;
    cb_size_t    wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
    pc_t         rd_addr;
    cb_size_t    rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
  } s_cb_mosi_t;
  typedef struct packed {
    logic        wr_addr_ready;
    logic        wr_data_ready;
    cb_error_t   wr_resp;
    logic        wr_resp_valid;
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    cb_error_t   rd_resp;
    logic        rd_valid;
  } s_cb_miso_t;
  typedef struct packed {
    logic active;
    pc_t  pc_addr;
    pc_t  mtval;
  } s_trap_info_t;
endpackage

module fetch_pf
  import nox_pkg::*;
#(
  parameter int L0_BUFFER_SIZE = 4,
  parameter int MAX_OT         = 2
) (
  input  logic         clk,
  input  logic         rst,
  output s_cb_mosi_t   instr_cb_mosi_o,
  input  s_cb_miso_t   instr_cb_miso_i,
  input  logic         fetch_start_i,
  input  pc_t          fetch_start_addr_i,
  input  logic         fetch_req_i,
  input  pc_t          fetch_addr_i,
  output logic         fetch_valid_o,
  input  logic         fetch_ready_i,
  output instr_raw_t   fetch_instr_o,
  output pc_t          fetch_pc_o,
  output s_trap_info_t trap_info_o
);
  localparam int OW = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;
  localparam int LW = (L0_BUFFER_SIZE > 1) ? $clog2(L0_BUFFER_SIZE) : 1;
  localparam int CW = $clog2(L0_BUFFER_SIZE + 1) + 1;
  localparam logic [CW-1:0] MAX_OT_C = CW'(MAX_OT);
  localparam logic [CW-1:0] L0_C     = CW'(L0_BUFFER_SIZE);

  // address phase
  pc_t        pc_q;
  logic       areq_q;
  pc_t        aaddr_q;
  logic       astale_q;
  logic       rd_ready_q;
  // outstanding tracker
  pc_t        ot_pc [MAX_OT];
  logic [MAX_OT-1:0] ot_live;
  logic [OW-1:0] ot_wp, ot_rp;
  logic [CW-1:0] ot_cnt;
  // L0 buffer
  instr_raw_t l0_instr [L0_BUFFER_SIZE];
  pc_t        l0_pc [L0_BUFFER_SIZE];
  logic [L0_BUFFER_SIZE-1:0] l0_fault;
  logic [LW-1:0] l0_wp, l0_rp;
  logic [CW-1:0] l0_occ;

  logic flush, stall, accept, rsp, push, pop, can_issue, seq_issue, jump_issue;
  logic [CW-1:0] ot_nxt, l0_nxt;
  logic unused_miso;

  assign unused_miso = ^{instr_cb_miso_i.wr_addr_ready, instr_cb_miso_i.wr_data_ready,
                         instr_cb_miso_i.wr_resp, instr_cb_miso_i.wr_resp_valid};

  function automatic logic [OW-1:0] ot_inc(input logic [OW-1:0] p);
    return (p == OW'(MAX_OT - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [LW-1:0] l0_inc(input logic [LW-1:0] p);
    return (p == LW'(L0_BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flush  = fetch_req_i | ~fetch_start_i;
  assign stall  = areq_q & ~instr_cb_miso_i.rd_addr_ready;
  assign accept = areq_q & instr_cb_miso_i.rd_addr_ready;
  // With ot_cnt = 0 any response belongs to traffic from before a reset.
  assign rsp    = instr_cb_miso_i.rd_valid & rd_ready_q & (ot_cnt != '0);
  assign push   = rsp & ot_live[ot_rp] & ~flush;
  assign pop    = fetch_valid_o & fetch_ready_i;

  // Credits are judged on next-cycle counts so that an accept and a response
  // landing together keep the one-per-cycle stream going without overshoot.
  assign ot_nxt    = ot_cnt + CW'(accept) - CW'(rsp);
  assign l0_nxt    = flush ? '0 : (l0_occ + CW'(push) - CW'(pop));
  assign can_issue = ~stall & (ot_nxt < MAX_OT_C) & ((ot_nxt + l0_nxt) < L0_C);
  assign seq_issue  = can_issue & fetch_start_i & ~fetch_req_i;
  // A jump drives its target onto the bus directly, saving a cycle of redirect.
  assign jump_issue = can_issue & fetch_start_i & fetch_req_i;

  always_comb begin
    instr_cb_mosi_o               = '0;
    instr_cb_mosi_o.rd_addr       = aaddr_q;
    instr_cb_mosi_o.rd_size       = areq_q ? CB_WORD : CB_BYTE;
    instr_cb_mosi_o.rd_addr_valid = areq_q;
    instr_cb_mosi_o.rd_ready      = rd_ready_q;
  end

  always_comb begin
    fetch_valid_o       = ~rst & fetch_start_i & ~fetch_req_i & (l0_occ != '0);
    fetch_instr_o       = fetch_valid_o ? l0_instr[l0_rp] : '0;
    fetch_pc_o          = fetch_valid_o ? l0_pc[l0_rp] : '0;
    trap_info_o         = '0;
    trap_info_o.active  = fetch_valid_o & l0_fault[l0_rp];
    trap_info_o.pc_addr = trap_info_o.active ? l0_pc[l0_rp] : '0;
    trap_info_o.mtval   = trap_info_o.active ? l0_pc[l0_rp] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= fetch_start_addr_i;
      areq_q     <= 1'b0;
      aaddr_q    <= '0;
      astale_q   <= 1'b0;
      rd_ready_q <= 1'b0;
      ot_wp      <= '0;
      ot_rp      <= '0;
      ot_cnt     <= '0;
      ot_live    <= '0;
      l0_wp      <= '0;
      l0_rp      <= '0;
      l0_occ     <= '0;
    end else begin
      rd_ready_q <= 1'b1;

      if (seq_issue) begin
        areq_q   <= 1'b1;
        aaddr_q  <= pc_q;
        astale_q <= 1'b0;
        pc_q     <= pc_q + 32'd4;
      end else if (jump_issue) begin
        areq_q   <= 1'b1;
        aaddr_q  <= fetch_addr_i;
        astale_q <= 1'b0;
        pc_q     <= fetch_addr_i + 32'd4;
      end else begin
        if (fetch_req_i) pc_q <= fetch_addr_i;
        // A stalled request must stay on the bus; it is only tagged stale.
        if (stall) astale_q <= astale_q | flush;
        else       areq_q   <= 1'b0;
      end

      ot_cnt <= ot_nxt;
      if (rsp) ot_rp <= ot_inc(ot_rp);
      if (flush) ot_live <= '0;
      if (accept) begin
        ot_pc[ot_wp]   <= aaddr_q;
        ot_live[ot_wp] <= ~astale_q & ~flush;
        ot_wp          <= ot_inc(ot_wp);
      end

      if (flush) begin
        l0_wp  <= '0;
        l0_rp  <= '0;
        l0_occ <= '0;
      end else begin
        if (push) begin
          l0_instr[l0_wp] <= instr_cb_miso_i.rd_data;
          l0_pc[l0_wp]    <= ot_pc[ot_rp];
          l0_fault[l0_wp] <= (instr_cb_miso_i.rd_resp != CB_OKAY);
          l0_wp           <= l0_inc(l0_wp);
        end
        if (pop) l0_rp <= l0_inc(l0_rp);
        l0_occ <= l0_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pf.sv
// tb/tb_fetch_pf.sv - directed scoreboard bench for fetch_pf
module tb_fetch_pf;
  import nox_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  s_cb_mosi_t   mosi;
  s_cb_miso_t   miso = '0;
  logic         fetch_start = 1'b1;
  logic [31:0]  start_addr = 32'h8000_0000;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = '0;
  logic         fetch_valid;
  logic         fetch_ready = 1'b0;
  logic [31:0]  fetch_instr;
  logic [31:0]  fetch_pc;
  s_trap_info_t trap;

  always #5 clk = ~clk;

  fetch_pf #(.L0_BUFFER_SIZE(4), .MAX_OT(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_cb_mosi_o    (mosi),
    .instr_cb_miso_i    (miso),
    .fetch_start_i      (fetch_start),
    .fetch_start_addr_i (start_addr),
    .fetch_req_i        (fetch_req),
    .fetch_addr_i       (fetch_addr),
    .fetch_valid_o      (fetch_valid),
    .fetch_ready_i      (fetch_ready),
    .fetch_instr_o      (fetch_instr),
    .fetch_pc_o         (fetch_pc),
    .trap_info_o        (trap)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mem_q[$];
  int checks = 0, errors = 0, cycle = 0;
  int lat = 1, n_acc = 0, pop_cnt = 0, first_pop = -1, last_pop = -1;
  logic addr_block = 1'b0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = base + 32'(4 * i);
      e.instr = instr_of(e.pc);
      e.fault = (e.pc == fault_addr);
      sb.push_back(e);
    end
  endtask

  task automatic mem_drive();
    mreq_t m;
    miso.rd_addr_ready = !addr_block;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      m = mem_q.pop_front();
      miso.rd_valid = 1'b1;
      miso.rd_data  = instr_of(m.addr);
      miso.rd_resp  = (m.addr == fault_addr) ? CB_SLVERR : CB_OKAY;
    end else begin
      miso.rd_valid = 1'b0;
      miso.rd_data  = '0;
      miso.rd_resp  = CB_OKAY;
    end
    if (mosi.rd_addr_valid && miso.rd_addr_ready) begin
      m.addr = mosi.rd_addr;
      m.due  = cycle + lat;
      mem_q.push_back(m);
      n_acc++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (fetch_valid) begin
      if (sb.size() > 0) begin
        chk("head_trap_active", {31'b0, trap.active}, {31'b0, sb[0].fault});
        chk("head_trap_mtval", trap.mtval, sb[0].fault ? sb[0].pc : 32'h0);
        if (fetch_ready) begin
          e = sb.pop_front();
          chk("pop_pc", fetch_pc, e.pc);
          chk("pop_instr", fetch_instr, e.instr);
          pop_cnt++;
          if (first_pop < 0) first_pop = cycle;
          last_pop = cycle;
        end
      end else if (fetch_ready) begin
        chk("unexpected_pop", {31'b0, fetch_valid}, 32'h0);
      end
    end else begin
      chk("idle_pc", fetch_pc, 32'h0);
      chk("idle_instr", fetch_instr, 32'h0);
      chk("idle_trap", {31'b0, trap.active}, 32'h0);
    end
  endtask

  task automatic cyc();
    mem_drive();
    #2;
    monitor();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic run_until_empty(input string tag, input int bound);
    int k = 0;
    while (sb.size() > 0 && k < bound) begin
      cyc();
      k++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset(input logic [31:0] addr);
    rst = 1'b1;
    start_addr = addr;
    fetch_req = 1'b0;
    repeat (5) cyc();
    mem_q.delete();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr_valid"}, {31'b0, mosi.rd_addr_valid}, 32'h0);
    chk({tag, "_rd_addr"}, mosi.rd_addr, 32'h0);
    chk({tag, "_rd_size"}, {29'b0, mosi.rd_size}, 32'h0);
    chk({tag, "_fetch_valid"}, {31'b0, fetch_valid}, 32'h0);
    chk({tag, "_fetch_instr"}, fetch_instr, 32'h0);
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, "_trap_active"}, {31'b0, trap.active}, 32'h0);
    chk({tag, "_trap_mtval"}, trap.mtval, 32'h0);
  endtask

  initial begin
    int k;
    // reset state
    do_reset(32'h8000_0000);
    rst = 1'b1;
    cyc();
    chk_all_zero("reset");

    // streaming, zero-wait memory
    do_reset(32'h8000_0000);
    lat = 1;
    fetch_ready = 1'b1;
    pop_cnt = 0;
    first_pop = -1;
    push_exp(32'h8000_0000, 8);
    run_until_empty("stream_drain", 60);
    chk("stream_count", pop_cnt, 8);
    chk("stream_span", last_pop - first_pop, 7);
    fetch_ready = 1'b0;

    // jump with two reads outstanding, latency 3
    do_reset(32'h8000_0000);
    lat = 3;
    fetch_ready = 1'b1;
    k = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due == cycle) && k < 20) begin
      cyc();
      k++;
    end
    chk("jump_wait_timeout", {31'b0, k < 20}, 32'h1);
    chk("jump_outstanding", mem_q.size(), 2);
    fetch_req = 1'b1;
    fetch_addr = 32'h8000_0100;
    cyc();
    fetch_req = 1'b0;
    chk("jump_rd_addr_valid", {31'b0, mosi.rd_addr_valid}, 32'h1);
    chk("jump_rd_addr", mosi.rd_addr, 32'h8000_0100);
    chk("jump_rd_size", {29'b0, mosi.rd_size}, {29'b0, CB_WORD});
    push_exp(32'h8000_0100, 4);
    run_until_empty("jump_drain", 60);
    fetch_ready = 1'b0;

    // address stall across a jump
    addr_block = 1'b1;
    do_reset(32'h8000_0000);
    lat = 1;
    k = 0;
    while (!mosi.rd_addr_valid && k < 10) begin
      cyc();
      k++;
    end
    chk("stall_first_addr", mosi.rd_addr, 32'h8000_0000);
    repeat (5) begin
      cyc();
      chk("stall_hold_valid", {31'b0, mosi.rd_addr_valid}, 32'h1);
      chk("stall_hold_addr", mosi.rd_addr, 32'h8000_0000);
    end
    fetch_req = 1'b1;
    fetch_addr = 32'h8000_0200;
    cyc();
    fetch_req = 1'b0;
    repeat (2) begin
      chk("stall_jump_hold_addr", mosi.rd_addr, 32'h8000_0000);
      cyc();
    end
    chk("stall_jump_hold_valid", {31'b0, mosi.rd_addr_valid}, 32'h1);
    addr_block = 1'b0;
    cyc();
    chk("stall_target_valid", {31'b0, mosi.rd_addr_valid}, 32'h1);
    chk("stall_target_addr", mosi.rd_addr, 32'h8000_0200);
    fetch_ready = 1'b1;
    push_exp(32'h8000_0200, 4);
    run_until_empty("stall_drain", 60);
    fetch_ready = 1'b0;

    // backpressure: credit limit of four
    do_reset(32'h8000_0000);
    lat = 1;
    n_acc = 0;
    repeat (20) cyc();
    chk("bp_issued", n_acc, 4);
    chk("bp_addr_idle", {31'b0, mosi.rd_addr_valid}, 32'h0);
    chk("bp_valid", {31'b0, fetch_valid}, 32'h1);
    fetch_ready = 1'b1;
    push_exp(32'h8000_0000, 8);
    run_until_empty("bp_drain", 60);
    fetch_ready = 1'b0;

    // access fault on 0x8000_0008
    fault_addr = 32'h8000_0008;
    do_reset(32'h8000_0000);
    repeat (10) cyc();
    push_exp(32'h8000_0000, 6);
    fetch_ready = 1'b1;
    cyc();
    cyc();
    fetch_ready = 1'b0;
    cyc();
    chk("fault_head_pc", fetch_pc, 32'h8000_0008);
    chk("fault_active", {31'b0, trap.active}, 32'h1);
    chk("fault_mtval", trap.mtval, 32'h8000_0008);
    chk("fault_pc_addr", trap.pc_addr, 32'h8000_0008);
    fetch_ready = 1'b1;
    run_until_empty("fault_drain", 60);
    fetch_ready = 1'b0;
    cyc();
    chk("fault_cleared", {31'b0, trap.active}, 32'h0);
    fault_addr = 32'hFFFF_FFFF;

    // stop with traffic outstanding, then restart
    do_reset(32'h8000_0000);
    lat = 3;
    fetch_ready = 1'b1;
    cyc();
    cyc();
    fetch_start = 1'b0;
    repeat (8) begin
      cyc();
      chk("stop_valid", {31'b0, fetch_valid}, 32'h0);
    end
    fetch_start = 1'b1;
    push_exp(32'h8000_0008, 3);
    run_until_empty("stop_resume", 60);

    // reset in the middle of a burst
    push_exp(32'h8000_0014, 40);
    repeat (5) cyc();
    rst = 1'b1;
    start_addr = 32'h4000_0000;
    sb.delete();
    cyc();
    chk_all_zero("midreset");
    do_reset(32'h4000_0000);
    lat = 1;
    push_exp(32'h4000_0000, 4);
    run_until_empty("after_reset", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
